// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP, 3-5 cycles per instruction.
// Waits on mem_ready for up to MEM_TIMEOUT cycles per request, then raises bus_err and traps.
module multicycle_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 mem_ready,
  input  logic                 br_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [2:0]           imm_sel,
  output logic [3:0]           alu_op,
  output logic                 alu_src_b,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal_instr,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, nstate;
  logic [WW-1:0] wait_cnt;
  logic [6:0]    opc;
  logic [2:0]    funct3;
  logic          legal;
  logic          timeout;
  logic          unused_instr_bits;

  assign opc               = instr[6:0];
  assign funct3            = instr[14:12];
  assign timeout           = (wait_cnt == WW'(MEM_TIMEOUT - 1));
  assign state_o           = state;
  assign unused_instr_bits = ^{instr[WIDTH-1:31], instr[29:15], instr[11:7]};

  always_comb begin
    legal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Selects are pure decode of the instruction and are valid in every state.
  always_comb begin
    imm_sel = 3'd0;
    alu_op  = 4'b0000;
    case (opc)
      OPC_STORE:           imm_sel = 3'd1;
      OPC_JAL:             imm_sel = 3'd2;
      OPC_BRANCH:          imm_sel = 3'd3;
      OPC_LUI, OPC_AUIPC:  imm_sel = 3'd4;
      default:             imm_sel = 3'd0;
    endcase
    if (opc == OPC_OP)
      alu_op = {instr[30], funct3};
    else if (opc == OPC_OPIMM)
      alu_op = (funct3 == 3'b001 || funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
  end

  always_comb begin
    nstate        = state;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'd0;
    alu_src_b     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    // Enables stay low while in reset so an abandoned instruction has no side effects.
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            nstate = DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
            nstate  = TRAP;
          end
        end
        DECODE: begin
          if (legal) begin
            nstate = EXEC;
          end else begin
            illegal_instr = 1'b1;
            nstate        = TRAP;
          end
        end
        EXEC: begin
          case (opc)
            OPC_LOAD, OPC_STORE: begin
              alu_src_b = 1'b1;
              nstate    = MEM;
            end
            OPC_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = br_taken ? 2'd1 : 2'd0;
              nstate = FETCH;
            end
            default: nstate = WB;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opc == OPC_STORE);
          if (mem_ready) begin
            if (opc == OPC_STORE) begin
              pc_we  = 1'b1;
              nstate = FETCH;
            end else begin
              nstate = WB;
            end
          end else if (timeout) begin
            bus_err = 1'b1;
            nstate  = TRAP;
          end
        end
        WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          nstate = FETCH;
          case (opc)
            OPC_LOAD: wb_sel = 2'd1;
            OPC_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
            OPC_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
            OPC_LUI:  wb_sel = 2'd3;
            default:  wb_sel = 2'd0;
          endcase
        end
        TRAP: begin
          pc_we  = 1'b1;
          pc_sel = 2'd3;
          nstate = FETCH;
        end
        default: nstate = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= nstate;
      if (nstate != state || !(state == FETCH || state == MEM))
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + WW'(1);
      if (pc_we && state != TRAP)
        instret <= instret + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/enable checks against hand-computed values.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_SUB   = 32'h40208033;
  localparam logic [31:0] I_SRAI  = 32'h4010d093;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LUI   = 32'h000000B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, br_taken;
  logic        ir_we, pc_we, alu_src_b, mem_req, mem_we, mem_addr_sel, rf_we;
  logic        illegal_instr, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [3:0]  alu_op;
  logic [31:0] instret;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WIDTH(32), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal_instr(illegal_instr), .bus_err(bus_err),
    .instret(instret), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Fetch/decode/exec/writeback path for register-writing, non-memory instructions.
  task automatic run_wb(input logic [31:0] iv, input logic [2:0] isel, input logic [1:0] wsel,
                        input logic [1:0] psel, input logic [3:0] aop);
    instr = iv; mem_ready = 1'b1;
    smp(); chk("f_state", state_o, 0); chk("f_instret", instret, exp_ret);
    chk("f_irwe", ir_we, 1); chk("f_memreq", mem_req, 1); chk("f_addrsel", mem_addr_sel, 0);
    tick();
    mem_ready = 1'b0;
    smp(); chk("d_state", state_o, 1); chk("d_illegal", illegal_instr, 0);
    tick();
    smp(); chk("e_state", state_o, 2); chk("e_aluop", alu_op, aop); chk("e_pcwe", pc_we, 0);
    tick();
    smp(); chk("w_state", state_o, 4); chk("w_rfwe", rf_we, 1); chk("w_pcwe", pc_we, 1);
    chk("w_wbsel", wb_sel, wsel); chk("w_pcsel", pc_sel, psel); chk("w_immsel", imm_sel, isel);
    chk("w_srcb", alu_src_b, 0);
    tick();
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr = I_ADDI; mem_ready = 1'b0; br_taken = 1'b0;
    tick(); tick();
    smp(); chk("rst_state", state_o, 0); chk("rst_instret", instret, 0);
    chk("rst_memreq", mem_req, 0); chk("rst_pcwe", pc_we, 0);
    tick();
    rst = 1'b0;

    run_wb(I_ADDI,  3'd0, 2'd0, 2'd0, 4'd0);
    run_wb(I_SUB,   3'd0, 2'd0, 2'd0, 4'd8);
    run_wb(I_SRAI,  3'd0, 2'd0, 2'd0, 4'd13);
    run_wb(I_JAL,   3'd2, 2'd2, 2'd1, 4'd0);
    run_wb(I_JALR,  3'd0, 2'd2, 2'd2, 4'd0);
    run_wb(I_LUI,   3'd4, 2'd3, 2'd0, 4'd0);
    run_wb(I_AUIPC, 3'd4, 2'd0, 2'd0, 4'd0);

    // LW abandoned by a two-cycle reset while waiting in MEM.
    instr = I_LW; mem_ready = 1'b1;
    smp(); chk("ra_f_instret", instret, exp_ret); tick();
    mem_ready = 1'b0;
    smp(); tick();
    smp(); tick();
    smp(); chk("ra_mem_state", state_o, 3); chk("ra_memreq", mem_req, 1); tick();
    rst = 1'b1; mem_ready = 1'b1;
    smp(); chk("ra_r1_pcwe", pc_we, 0); chk("ra_r1_rfwe", rf_we, 0); chk("ra_r1_memreq", mem_req, 0);
    tick();
    smp(); chk("ra_r2_state", state_o, 0); chk("ra_r2_instret", instret, 0);
    chk("ra_r2_irwe", ir_we, 0); chk("ra_r2_pcwe", pc_we, 0);
    tick();
    rst = 1'b0; mem_ready = 1'b0; exp_ret = 0;

    // LW with mem_ready arriving on the fourth MEM cycle: 8 cycles total.
    instr = I_LW; mem_ready = 1'b1;
    smp(); chk("lw_f_state", state_o, 0); chk("lw_f_instret", instret, exp_ret); tick();
    mem_ready = 1'b0;
    smp(); chk("lw_d_state", state_o, 1); tick();
    smp(); chk("lw_e_state", state_o, 2); chk("lw_e_srcb", alu_src_b, 1); tick();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      smp(); chk("lw_m_state", state_o, 3); chk("lw_m_addrsel", mem_addr_sel, 1);
      chk("lw_m_we", mem_we, 0); chk("lw_m_req", mem_req, 1); chk("lw_m_pcwe", pc_we, 0);
      tick();
    end
    mem_ready = 1'b0;
    smp(); chk("lw_w_state", state_o, 4); chk("lw_w_wbsel", wb_sel, 1);
    chk("lw_w_immsel", imm_sel, 0); chk("lw_w_rfwe", rf_we, 1);
    tick();
    exp_ret++;

    // BEQ taken, then not taken.
    for (int t = 0; t < 2; t++) begin
      br_taken = (t == 0); instr = I_BEQ; mem_ready = 1'b1;
      smp(); chk("beq_f_state", state_o, 0); chk("beq_f_instret", instret, exp_ret); tick();
      mem_ready = 1'b0;
      smp(); chk("beq_d_state", state_o, 1); tick();
      smp(); chk("beq_e_state", state_o, 2); chk("beq_e_pcwe", pc_we, 1);
      chk("beq_e_pcsel", pc_sel, (t == 0) ? 1 : 0); chk("beq_e_immsel", imm_sel, 3);
      chk("beq_e_rfwe", rf_we, 0);
      tick();
      exp_ret++;
    end
    br_taken = 1'b0;

    // SW completes in MEM with immediate mem_ready.
    instr = I_SW; mem_ready = 1'b1;
    smp(); chk("sw_f_instret", instret, exp_ret); tick();
    mem_ready = 1'b0;
    smp(); tick();
    smp(); chk("sw_e_srcb", alu_src_b, 1); tick();
    mem_ready = 1'b1;
    smp(); chk("sw_m_state", state_o, 3); chk("sw_m_we", mem_we, 1); chk("sw_m_addrsel", mem_addr_sel, 1);
    chk("sw_m_pcwe", pc_we, 1); chk("sw_m_pcsel", pc_sel, 0); chk("sw_m_immsel", imm_sel, 1);
    chk("sw_m_rfwe", rf_we, 0);
    tick();
    exp_ret++;

    // Illegal opcode traps without retiring.
    instr = I_ILL; mem_ready = 1'b1;
    smp(); chk("ill_f_instret", instret, exp_ret); tick();
    mem_ready = 1'b0;
    smp(); chk("ill_d_state", state_o, 1); chk("ill_d_pulse", illegal_instr, 1); tick();
    smp(); chk("ill_t_state", state_o, 5); chk("ill_t_pcwe", pc_we, 1); chk("ill_t_pcsel", pc_sel, 3);
    chk("ill_t_pulse", illegal_instr, 0);
    tick();

    // Fetch timeout: bus_err on the 16th FETCH cycle only.
    instr = I_ADDI; mem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      smp(); chk("to_state", state_o, 0); chk("to_buserr", bus_err, (k == 16) ? 1 : 0);
      if (k == 1) chk("to_instret", instret, exp_ret);
      tick();
    end
    smp(); chk("to_t_state", state_o, 5); chk("to_t_pcsel", pc_sel, 3); chk("to_t_pcwe", pc_we, 1);
    chk("to_t_buserr", bus_err, 0);
    tick();

    // mem_ready arriving on the timeout cycle wins.
    for (int k = 1; k <= 16; k++) begin
      mem_ready = (k == 16);
      smp(); chk("lr_buserr", bus_err, 0);
      if (k == 16) chk("lr_irwe", ir_we, 1);
      tick();
    end
    mem_ready = 1'b0;
    smp(); chk("lr_d_state", state_o, 1); tick();
    smp(); chk("lr_e_state", state_o, 2); tick();
    smp(); chk("lr_w_state", state_o, 4); tick();
    exp_ret++;
    smp(); chk("final_state", state_o, 0); chk("final_instret", instret, exp_ret);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
